// File: rtl/mem_dump_sequencer.sv
// Memory dump sequencer: reads a byte range and streams it as lowercase hex text with CR LF line breaks.
// Optional feature macro MEM_DUMP_ADDR_PREFIX_EN prefixes every line with "<addr>: ".
module mem_dump_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        uart_data,
  input  logic              read_start_set,
  input  logic              read_end_set,
  input  logic              read_stop,
  output logic              dump_running,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_HI,
    S_LO,
    S_SP,
    S_CR,
    S_LF,
    S_DONE
`ifdef MEM_DUMP_ADDR_PREFIX_EN
    ,
    S_APFX,
    S_COLON,
    S_ASP
`endif
  } state_t;

  localparam logic [7:0] LAST_IN_LINE = 8'(BYTES_PER_LINE - 1);

`ifdef MEM_DUMP_ADDR_PREFIX_EN
  localparam int         NIBS     = (ADDR_W + 3) / 4;
  localparam int         PAD_W    = NIBS * 4;
  localparam logic [7:0] LAST_NIB = 8'(NIBS - 1);
  // Every line opens with the address prefix before its first read.
  localparam state_t     FIRST    = S_APFX;
`else
  localparam state_t     FIRST    = S_READ;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [7:0]        line_q, line_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              stop_q, stop_d;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
  logic [7:0]        nib_q, nib_d;
`endif

  logic [ADDR_W-1:0] data_ext;
  logic [ADDR_W-1:0] start_eff;
  logic              is_tx;
  logic              hs;
  logic              stop_any;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

`ifdef MEM_DUMP_ADDR_PREFIX_EN
  function automatic logic [3:0] addr_nib(input logic [ADDR_W-1:0] a, input logic [7:0] idx);
    logic [PAD_W-1:0] pad;
    pad = PAD_W'(a);
    return pad[(NIBS - 1 - int'(idx)) * 4 +: 4];
  endfunction
`endif

  assign data_ext  = ADDR_W'(uart_data);
  // A start strobe in the same cycle as the end strobe must already be seen.
  assign start_eff = read_start_set ? data_ext : start_q;
  assign hs        = is_tx & tx_ready;
  assign stop_any  = read_stop | stop_q;

  always_comb begin
    is_tx = 1'b0;
    case (state_q)
      S_HI, S_LO, S_SP, S_CR, S_LF: is_tx = 1'b1;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
      S_APFX, S_COLON, S_ASP:       is_tx = 1'b1;
`endif
      default:                      is_tx = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d   = state_q;
    start_d   = start_q;
    end_d     = end_q;
    cur_d     = cur_q;
    line_d    = line_q;
    byte_d    = byte_q;
    stop_d    = stop_q;
    tx_data_d = 8'h00;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
    nib_d     = nib_q;
`endif

    if (read_start_set) start_d = data_ext;

    case (state_q)
      S_IDLE: begin
        if (read_end_set && !read_stop) begin
          end_d   = data_ext;
          cur_d   = start_eff;
          line_d  = 8'd0;
          state_d = (data_ext < start_eff) ? S_DONE : FIRST;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
          nib_d   = 8'd0;
`endif
        end
      end
      S_READ: state_d = read_stop ? S_IDLE : S_WAIT;
      S_WAIT: begin
        byte_d  = mem_rdata;
        state_d = read_stop ? S_IDLE : S_HI;
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        // Transmit states: a stop lets the pending character finish first.
        if (hs && stop_any) begin
          state_d = S_IDLE;
        end else if (hs) begin
          case (state_q)
            S_HI: state_d = S_LO;
            S_LO: state_d = (cur_q == end_q || line_q == LAST_IN_LINE) ? S_CR : S_SP;
            S_SP: begin
              cur_d   = cur_q + ADDR_W'(1);
              line_d  = line_q + 8'd1;
              state_d = S_READ;
            end
            S_CR: state_d = S_LF;
            S_LF: begin
              if (cur_q == end_q) begin
                state_d = S_DONE;
              end else begin
                cur_d   = cur_q + ADDR_W'(1);
                line_d  = 8'd0;
                state_d = FIRST;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
                nib_d   = 8'd0;
`endif
              end
            end
`ifdef MEM_DUMP_ADDR_PREFIX_EN
            S_APFX: begin
              if (nib_q == LAST_NIB) state_d = S_COLON;
              else                   nib_d   = nib_q + 8'd1;
            end
            S_COLON: state_d = S_ASP;
            S_ASP:   state_d = S_READ;
`endif
            default: state_d = S_IDLE;
          endcase
        end else if (read_stop) begin
          stop_d = 1'b1;
        end
      end
    endcase

    if (state_d == S_IDLE) stop_d = 1'b0;

    // tx_data is registered from the next state so it is stable for the whole handshake.
    case (state_d)
      S_HI:    tx_data_d = hex_char(byte_d[7:4]);
      S_LO:    tx_data_d = hex_char(byte_d[3:0]);
      S_SP:    tx_data_d = 8'h20;
      S_CR:    tx_data_d = 8'h0d;
      S_LF:    tx_data_d = 8'h0a;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
      S_APFX:  tx_data_d = hex_char(addr_nib(cur_d, nib_d));
      S_COLON: tx_data_d = 8'h3a;
      S_ASP:   tx_data_d = 8'h20;
`endif
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      end_q     <= '0;
      cur_q     <= '0;
      line_q    <= 8'd0;
      byte_q    <= 8'd0;
      tx_data_q <= 8'd0;
      stop_q    <= 1'b0;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
      nib_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      end_q     <= end_d;
      cur_q     <= cur_d;
      line_q    <= line_d;
      byte_q    <= byte_d;
      tx_data_q <= tx_data_d;
      stop_q    <= stop_d;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
      nib_q     <= nib_d;
`endif
    end
  end

  assign tx_valid     = is_tx;
  assign tx_data      = tx_data_q;
  assign mem_re       = (state_q == S_READ);
  assign mem_raddr    = cur_q;
  assign dump_running = (state_q != S_IDLE) | (read_end_set & (state_q == S_IDLE));

endmodule

// File: doc/mem_dump_sequencer.md
Name: mem_dump_sequencer

Overview:
- Executes the monitor's "r <start> <end>" memory-dump command.
- Captures the start and end addresses strobed in by the UART command controller, then reads data memory one byte at a time.
- Converts each byte to two lowercase ASCII hex characters and streams them to the UART transmitter over a valid/ready handshake, with CR LF line breaks.
- Drives dump_running back to the command controller so it can leave its dump state when the dump completes.

Parameters:
- ADDR_W, 8: memory address width. uart_data is zero-extended to ADDR_W.
- BYTES_PER_LINE, 16: bytes printed per output line, range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- uart_data  in  8  address byte from the command controller
- read_start_set  in  1  one-cycle pulse; latch uart_data as start address
- read_end_set  in  1  one-cycle pulse; latch uart_data as end address and begin the dump
- read_stop  in  1  one-cycle pulse; abort the dump
- dump_running  out  1  dump in progress
- mem_re  out  1  memory read enable, one-cycle pulse
- mem_raddr  out  ADDR_W  memory read address
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re
- tx_data  out  8  ASCII character to the UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle

Behaviour:
- Reset, synchronous on rst:
  - state=IDLE; all registers cleared.
  - dump_running=0, mem_re=0, mem_raddr=0, tx_data=0, tx_valid=0.
- Address capture:
  - read_start_set loads start_addr; accepted in any state.
  - read_end_set loads end_addr, sets cur_addr=start_addr and line_cnt=0, and moves to READ. Ignored unless state=IDLE.
- dump_running is combinational: (state!=IDLE) | (read_end_set & state==IDLE). The controller therefore sees it high in the same cycle as read_end_set.
- Empty range: if end_addr < start_addr at read_end_set, go to DONE. No memory reads and no characters are sent. dump_running is high for the read_end_set cycle plus one cycle.
- States:
  - IDLE: wait for read_end_set.
  - READ: mem_re=1, mem_raddr=cur_addr; next state WAIT.
  - WAIT: capture mem_rdata into byte_reg; next state HI.
  - HI: tx_data = hex(byte_reg[7:4]); advance to LO on tx_valid & tx_ready.
  - LO: tx_data = hex(byte_reg[3:0]). On handshake:
    - if cur_addr==end_addr or line_cnt==BYTES_PER_LINE-1, go to CR;
    - else go to SP.
  - SP: tx_data=0x20. On handshake, cur_addr++, line_cnt++, go to READ.
  - CR: tx_data=0x0d; go to LF on handshake.
  - LF: tx_data=0x0a. On handshake:
    - if cur_addr==end_addr, go to DONE;
    - else cur_addr++, line_cnt=0, go to READ.
  - DONE: one cycle, then IDLE.
- Hex encoding: 0-9 map to 0x30-0x39; a-f map to 0x61-0x66, lowercase only.
- Transmit handshake:
  - tx_valid=1 in HI, LO, SP, CR and LF; 0 in all other states.
  - tx_data is registered and stable while tx_valid=1 and tx_ready=0.
  - Each character transfers exactly once, on the cycle where tx_valid & tx_ready.
- No separator space is sent before CR. The last byte of a range always ends with CR LF.
- Wrap-around: the end test uses cur_addr==end_addr before increment, so end_addr=2^ADDR_W-1 terminates without wrapping. cur_addr never increments past end_addr.
- read_stop:
  - In READ, WAIT or DONE: go to IDLE next cycle.
  - In a tx state with tx_valid=1 and tx_ready=0: finish that handshake, then go to IDLE. No CR LF is appended.
  - In IDLE: ignored.
  - read_stop together with read_end_set in IDLE: the stop wins and the dump does not start.
- Simultaneous read_start_set and read_end_set: start_addr and end_addr both load uart_data, giving a one-byte dump.
- rst asserted mid-dump: immediate return to IDLE; any pending character is dropped and tx_valid=0 next cycle.

Optional Feature:
- Macro: MEM_DUMP_ADDR_PREFIX_EN.
- Defined:
  - Each line begins with the address of its first byte, as ADDR_W/4 hex characters (rounded up), followed by 0x3a ':' and 0x20.
  - Sent through extra states AHI..ALO, COLON and ASP before that line's first READ.
  - line_cnt is unaffected by the prefix.
- Undefined: no prefix characters; the prefix states are absent.

Test Plan:
- Basic dump: start=0x10, end=0x12, mem=a5,3c,00, tx_ready=1 -> tx stream "a5 3c 00\r\n" (61 35 20 33 63 20 30 30 0d 0a). dump_running falls 2 cycles after the final LF handshake.
- Line wrap: start=0x00, end=0x10, BYTES_PER_LINE=16 -> 16 bytes, CR LF, 1 byte, CR LF. Exactly 17 mem_re pulses with addresses 0x00..0x10.
- Backpressure: tx_ready toggles 1-of-3 cycles -> tx_data and tx_valid stable while stalled, no duplicate or lost characters, same stream as in the no-stall case.
- Boundaries:
  - start=end=0xff -> "xx\r\n", with no wrap to 0x00.
  - start=0x20, end=0x1f -> no mem_re, no tx_valid, dump_running high for 2 cycles.
- Abort: read_stop pulsed while in LO with tx_ready=0 -> that character completes, state=IDLE, no further mem_re or tx_valid. rst pulsed mid-dump -> tx_valid=0 next cycle.
- With MEM_DUMP_ADDR_PREFIX_EN: start=0x0e, end=0x11 -> "0e: xx xx xx xx\r\n"; with BYTES_PER_LINE=2 -> "0e: xx xx\r\n10: xx xx\r\n".
